timer_counter: RTL and testbench
================================

# timer_counter

Programmable down-counting timer that raises a hardware interrupt request for the CP0 interrupt controller. One instance drives one bit of CP0's six-bit `HWint` input. Software programs it via word-addressed register writes from the bridge and clears the request by rewriting a register. Interrupts are level requests: `irq` stays asserted until software clears the pending flag.

## Interface
Parameters:
- `PRESET_RST`, default 32'h0000_0000: reset value of the PRESET register.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `addr` in 2: word address, byte offset [3:2]; 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved.
- `we` in 1: register write strobe, sampled at rising edge.
- `din` in 32: write data.
- `dout` out 32: read data, combinational from `addr`.
- `irq` out 1: interrupt request to a CP0 `HWint` bit.

## Operation
CTRL register (other bits read 0, writes ignored):
- [0] EN: count enable.
- [2:1] MODE: 00 = one-shot, 01 = auto-reload; 10 and 11 behave as 00.
- [3] IM: interrupt mask, 1 = allow `irq`.

Register access:
- PRESET: read/write.
- COUNT: read-only; writes ignored.
- Reserved address reads 0.

State machine, 2-bit state, reset to IDLE:
- IDLE: if EN = 1, go to LOAD.
- LOAD: COUNT <= PRESET; go to CNT.
- CNT: if EN = 0, go to IDLE with COUNT held. Else if COUNT = 0, go to INT and set PEND. Else COUNT <= COUNT - 1.
- INT, mode 00: hardware clears EN; go to IDLE.
- INT, mode 01: go to LOAD; EN unchanged.

Interrupt and pending flag:
- `irq` = PEND & IM.
- PEND is cleared by any write to CTRL or PRESET.
- If a clear and a set land in the same cycle, the set wins.

Counter arithmetic:
- 32-bit unsigned.
- COUNT never decrements below 0, so there is no wrap-around.
- PRESET = 0 is legal: CNT sees 0 immediately and the period is minimal.

Writes during operation:
- Writing PRESET mid-count does not affect the current COUNT; it takes effect at the next LOAD.
- Writing CTRL with EN = 0 while in LOAD or CNT: the machine goes to IDLE on the following edge.
- A software CTRL write in the same cycle as the INT-state hardware EN clear: the software value wins.

Reset values:
- CTRL = 0, PRESET = PRESET_RST, COUNT = 0, PEND = 0, state = IDLE.
- `irq` = 0; `dout` reflects the reset register values.
- Reset asserted mid-count aborts the count at once, with no `irq` pulse.

## Timing
Writes:
- A write lands on the edge where `we` = 1.
- Reads are combinational with zero latency.

One-shot sequence with PRESET = N, write CTRL = 4'b1001 at edge E0:
- E1: LOAD.
- E2: CNT, COUNT = N.
- E2+N: COUNT = 0.
- E3+N: INT; PEND = 1, `irq` = 1.
- E4+N: IDLE; EN = 0.
- Period from enable write to `irq` is N + 3 cycles.

Auto-reload:
- Interrupt spacing is N + 3 cycles (INT → LOAD → CNT → N decrements → INT).
- PEND stays set across periods until cleared.

Masking:
- `irq` follows IM combinationally.
- Setting IM while PEND = 1 raises `irq` in the same cycle the write lands.

## Configuration
- `TC_AUTO_RELOAD_EN` defined: MODE bits are implemented and mode 01 reloads as described.
- `TC_AUTO_RELOAD_EN` undefined: CTRL[2:1] are not stored and read 0, INT always clears EN and returns to IDLE, and the block is one-shot only.

## Test plan
- Reset: assert `reset` mid-count with COUNT = 7 → all registers and `irq` read 0 immediately, PRESET = PRESET_RST, no `irq` after release.
- One-shot: PRESET = 5, CTRL = 9 at E0 → `irq` rises at E8, CTRL reads 8 from E9, COUNT stays 0; a write of CTRL = 0 drops `irq` on the next edge.
- Auto-reload (macro on): PRESET = 3, CTRL = 11, clear PEND after each `irq` → `irq` rises every 6 cycles for 4 periods.
- Macro off: CTRL = 11 → reads back 9; single `irq` after 6 cycles, then IDLE with no reload.
- Mask and disable: IM = 0 with PEND set → `irq` = 0; then set IM → `irq` = 1 the same cycle. Writing EN = 0 at COUNT = 2 → IDLE next edge, COUNT holds 2.
- Collision: in mode 01, software writes PRESET on the same edge CNT → INT → PEND ends at 1 and `irq` stays high.

Source files
------------

// File: rtl/timer_counter.sv
// -----------------------------------------------------------------------------
// timer_counter
//
// Programmable down-counting timer that raises a level interrupt request for
// one bit of the CP0 HWint input. Software programs CTRL and PRESET through
// word-addressed writes. COUNT is read-only. The request stays asserted until
// software rewrites CTRL or PRESET, which clears the pending flag.
//
// Register map (addr = byte offset [3:2]):
//   0  CTRL    [0] EN count enable, [2:1] MODE (00 one-shot, 01 auto-reload,
//              10/11 act as 00), [3] IM interrupt mask; other bits read 0
//   1  PRESET  read/write reload value
//   2  COUNT   read-only current count
//   3  reserved, reads 0
//
// Configuration macro:
//   TC_AUTO_RELOAD_EN  defined   : MODE bits are stored and mode 01 reloads.
//                      undefined : MODE is not stored and reads 0. Every
//                                  expiry clears EN (one-shot only).
//
// Parameters:
//   PRESET_RST  reset value of the PRESET register
//
// Ports:
//   clk    in   1   rising-edge clock
//   reset  in   1   asynchronous active-high reset
//   addr   in   2   word address
//   we     in   1   write strobe, sampled on the rising edge
//   din    in  32   write data
//   dout   out 32   combinational read data selected by addr
//   irq    out  1   interrupt request (PEND & IM)
// -----------------------------------------------------------------------------
module timer_counter #(
    parameter logic [31:0] PRESET_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        en;
    logic        en_nxt;
    logic        im;
    logic [1:0]  mode;
    logic [31:0] preset;
    logic [31:0] count;
    logic [31:0] count_nxt;
    logic        pend;
    logic        pend_nxt;

    logic        wr_ctrl;
    logic        wr_preset;
    logic        pend_set;
    logic        hw_en_clr;
    logic        reload_mode;

    // Saturating decrement: COUNT never wraps below zero.
    function automatic logic [31:0] sat_dec(input logic [31:0] v);
        if (v == 32'd0) begin
            return 32'd0;
        end
        return v - 32'd1;
    endfunction

    assign wr_ctrl   = we && (addr == ADDR_CTRL);
    assign wr_preset = we && (addr == ADDR_PRESET);

    // -------------------------------------------------------------------------
    // Mode storage (only present when auto-reload is built in)
    // -------------------------------------------------------------------------
`ifdef TC_AUTO_RELOAD_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode <= 2'b00;
        end else if (wr_ctrl) begin
            mode <= din[2:1];
        end
    end

    // Only the 01 encoding reloads; 10 and 11 fall back to one-shot.
    assign reload_mode = (mode == 2'b01);
`else
    assign mode        = 2'b00;
    assign reload_mode = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next-state and counter logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        pend_set  = 1'b0;
        hw_en_clr = 1'b0;

        unique case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                count_nxt = preset;
                state_nxt = CNT;
            end
            CNT: begin
                if (!en) begin
                    // Disabled mid-count: COUNT is held for software to read.
                    state_nxt = IDLE;
                end else if (count == 32'd0) begin
                    state_nxt = INT;
                    pend_set  = 1'b1;
                end else begin
                    count_nxt = sat_dec(count);
                end
            end
            INT: begin
                if (reload_mode) begin
                    state_nxt = LOAD;
                end else begin
                    hw_en_clr = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // A software CTRL write overrides the hardware EN clear on the same edge.
    always_comb begin
        en_nxt = en;
        if (wr_ctrl) begin
            en_nxt = din[0];
        end else if (hw_en_clr) begin
            en_nxt = 1'b0;
        end
    end

    // The hardware set takes priority over a software clear on the same edge.
    always_comb begin
        pend_nxt = pend;
        if (pend_set) begin
            pend_nxt = 1'b1;
        end else if (wr_ctrl || wr_preset) begin
            pend_nxt = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // State and register update
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            en     <= 1'b0;
            im     <= 1'b0;
            preset <= PRESET_RST;
            count  <= 32'd0;
            pend   <= 1'b0;
        end else begin
            state <= state_nxt;
            en    <= en_nxt;
            count <= count_nxt;
            pend  <= pend_nxt;
            if (wr_ctrl) begin
                im <= din[3];
            end
            // A new PRESET only reaches COUNT at the next LOAD.
            if (wr_preset) begin
                preset <= din;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read mux and interrupt output
    // -------------------------------------------------------------------------
    always_comb begin
        dout = 32'd0;
        unique case (addr)
            ADDR_CTRL:   dout = {28'd0, im, mode, en};
            ADDR_PRESET: dout = preset;
            ADDR_COUNT:  dout = count;
            default:     dout = 32'd0;
        endcase
    end

    assign irq = pend & im;

endmodule

// File: tb/tb_timer_counter.sv
module tb_timer_counter;

    localparam logic [31:0] TB_PRESET_RST = 32'h0000_0123;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int errors = 0;
    int checks = 0;

    timer_counter #(.PRESET_RST(TB_PRESET_RST)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .din   (din),
        .dout  (dout),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [1:0]  a;
        logic [31:0] d;
        logic [1:0]  ra;
        logic [31:0] exp_d;
        logic        exp_irq;
        string       name;
    } vec_t;

    vec_t vec[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, let the edge land, then select a read address.
    task automatic cyc(input logic w, input logic [1:0] a, input logic [31:0] d, input logic [1:0] ra);
        @(negedge clk);
        we   = w;
        addr = a;
        din  = d;
        @(posedge clk);
        #1;
        we   = 1'b0;
        addr = ra;
        din  = 32'd0;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        we    = 1'b0;
        addr  = 2'd0;
        din   = 32'd0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        we    = 1'b0;
        addr  = 2'd0;
        din   = 32'd0;

        // One-shot, PRESET = 5, CTRL = 9 at E0
        vec[0]  = '{1'b1, 2'd1, 32'd5, 2'd1, 32'd5, 1'b0, "os_preset_wr"};
        vec[1]  = '{1'b1, 2'd0, 32'd9, 2'd0, 32'd9, 1'b0, "os_ctrl_E0"};
        vec[2]  = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd0, 1'b0, "os_load_E1"};
        vec[3]  = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd5, 1'b0, "os_cnt_E2"};
        vec[4]  = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd4, 1'b0, "os_cnt_E3"};
        vec[5]  = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd3, 1'b0, "os_cnt_E4"};
        vec[6]  = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd2, 1'b0, "os_cnt_E5"};
        vec[7]  = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd1, 1'b0, "os_cnt_E6"};
        vec[8]  = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd0, 1'b0, "os_cnt_E7"};
        vec[9]  = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd0, 1'b1, "os_irq_E8"};
        vec[10] = '{1'b0, 2'd0, 32'd0, 2'd0, 32'd8, 1'b1, "os_ctrl_E9"};
        vec[11] = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd0, 1'b1, "os_count_E10"};
        vec[12] = '{1'b1, 2'd0, 32'd0, 2'd0, 32'd0, 1'b0, "os_clear_E11"};
        vec[13] = '{1'b0, 2'd0, 32'd0, 2'd2, 32'd0, 1'b0, "os_idle_E12"};

        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        addr = 2'd0; #1; chk("rst_ctrl", dout, 32'd0);
        addr = 2'd1; #1; chk("rst_preset", dout, TB_PRESET_RST);
        addr = 2'd2; #1; chk("rst_count", dout, 32'd0);
        addr = 2'd3; #1; chk("rst_reserved", dout, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);

        // Table-driven one-shot sequence
        for (int i = 0; i < 14; i++) begin
            cyc(vec[i].w, vec[i].a, vec[i].d, vec[i].ra);
            chk({vec[i].name, "_dout"}, dout, vec[i].exp_d);
            chk({vec[i].name, "_irq"}, {31'd0, irq}, {31'd0, vec[i].exp_irq});
        end

        // Reset mid-count at COUNT = 7
        do_reset();
        cyc(1'b1, 2'd1, 32'd10, 2'd2);
        cyc(1'b1, 2'd0, 32'd9, 2'd2);
        for (int k = 1; k <= 5; k++) cyc(1'b0, 2'd0, 32'd0, 2'd2);
        chk("mid_count7", dout, 32'd7);
        @(negedge clk);
        #1;
        reset = 1'b1;
        addr = 2'd0; #1; chk("mid_rst_ctrl", dout, 32'd0);
        chk("mid_rst_irq", {31'd0, irq}, 32'd0);
        addr = 2'd1; #1; chk("mid_rst_preset", dout, TB_PRESET_RST);
        addr = 2'd2; #1; chk("mid_rst_count", dout, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 15; k++) begin
            cyc(1'b0, 2'd0, 32'd0, 2'd2);
            chk("post_rst_irq", {31'd0, irq}, 32'd0);
            chk("post_rst_count", dout, 32'd0);
        end

`ifdef TC_AUTO_RELOAD_EN
        // Auto-reload: PRESET = 3, irq every 6 cycles, PEND cleared each period
        do_reset();
        cyc(1'b1, 2'd1, 32'd3, 2'd1);
        cyc(1'b1, 2'd0, 32'd11, 2'd0);
        chk("ar_ctrl_rd", dout, 32'd11);
        for (int p = 0; p < 4; p++) begin
            cyc(1'b1, 2'd0, 32'd11, 2'd2);
            chk("ar_irq_low", {31'd0, irq}, 32'd0);
            for (int k = 2; k <= 5; k++) begin
                cyc(1'b0, 2'd0, 32'd0, 2'd2);
                chk("ar_irq_low", {31'd0, irq}, 32'd0);
            end
            cyc(1'b0, 2'd0, 32'd0, 2'd2);
            chk("ar_irq_rise", {31'd0, irq}, 32'd1);
        end
`else
        // One-shot only build: MODE not stored, no reload
        do_reset();
        cyc(1'b1, 2'd1, 32'd3, 2'd1);
        cyc(1'b1, 2'd0, 32'd11, 2'd0);
        chk("nm_ctrl_rd", dout, 32'd9);
        for (int k = 1; k <= 5; k++) begin
            cyc(1'b0, 2'd0, 32'd0, 2'd2);
            chk("nm_irq_low", {31'd0, irq}, 32'd0);
        end
        cyc(1'b0, 2'd0, 32'd0, 2'd2);
        chk("nm_irq_rise", {31'd0, irq}, 32'd1);
        cyc(1'b0, 2'd0, 32'd0, 2'd0);
        chk("nm_ctrl_after", dout, 32'd8);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 2'd0, 32'd0, 2'd2);
            chk("nm_no_reload", dout, 32'd0);
            chk("nm_irq_held", {31'd0, irq}, 32'd1);
        end
`endif

        // Masking: PEND set with IM = 0, then IM set on the edge PEND is set
        do_reset();
        cyc(1'b1, 2'd1, 32'd0, 2'd1);
        chk("mk_preset0", dout, 32'd0);
        cyc(1'b1, 2'd0, 32'd1, 2'd0);
        cyc(1'b0, 2'd0, 32'd0, 2'd2);
        cyc(1'b0, 2'd0, 32'd0, 2'd2);
        cyc(1'b0, 2'd0, 32'd0, 2'd2);
        chk("mk_masked_irq", {31'd0, irq}, 32'd0);
        cyc(1'b0, 2'd0, 32'd0, 2'd0);
        chk("mk_en_cleared", dout, 32'd0);
        chk("mk_masked_irq2", {31'd0, irq}, 32'd0);
        cyc(1'b1, 2'd0, 32'd1, 2'd0);
        cyc(1'b0, 2'd0, 32'd0, 2'd2);
        cyc(1'b0, 2'd0, 32'd0, 2'd2);
        cyc(1'b1, 2'd0, 32'd9, 2'd0);
        chk("mk_im_same_cycle", {31'd0, irq}, 32'd1);
        chk("mk_ctrl_rd", dout, 32'd9);
        cyc(1'b0, 2'd0, 32'd0, 2'd0);
        chk("mk_hw_en_clr", dout, 32'd8);
        chk("mk_irq_held", {31'd0, irq}, 32'd1);

        // Disable mid-count: COUNT holds 2
        do_reset();
        cyc(1'b1, 2'd1, 32'd6, 2'd1);
        cyc(1'b1, 2'd0, 32'd9, 2'd2);
        for (int k = 1; k <= 5; k++) cyc(1'b0, 2'd0, 32'd0, 2'd2);
        chk("dis_count3", dout, 32'd3);
        cyc(1'b1, 2'd0, 32'd8, 2'd2);
        chk("dis_count2", dout, 32'd2);
        cyc(1'b0, 2'd0, 32'd0, 2'd2);
        chk("dis_hold_idle", dout, 32'd2);
        cyc(1'b1, 2'd2, 32'd99, 2'd2);
        chk("dis_count_ro", dout, 32'd2);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 2'd0, 32'd0, 2'd2);
            chk("dis_hold", dout, 32'd2);
            chk("dis_irq", {31'd0, irq}, 32'd0);
        end
        cyc(1'b1, 2'd3, 32'd5, 2'd3);
        chk("dis_reserved", dout, 32'd0);

        // Collision: PRESET write on the CNT -> INT edge
        do_reset();
        cyc(1'b1, 2'd1, 32'd2, 2'd1);
        cyc(1'b1, 2'd0, 32'd11, 2'd0);
        for (int k = 1; k <= 4; k++) cyc(1'b0, 2'd0, 32'd0, 2'd2);
        chk("col_count0", dout, 32'd0);
        chk("col_irq_before", {31'd0, irq}, 32'd0);
        cyc(1'b1, 2'd1, 32'd7, 2'd1);
        chk("col_irq", {31'd0, irq}, 32'd1);
        chk("col_preset", dout, 32'd7);
        cyc(1'b0, 2'd0, 32'd0, 2'd2);
        chk("col_irq_held", {31'd0, irq}, 32'd1);
`ifdef TC_AUTO_RELOAD_EN
        cyc(1'b0, 2'd0, 32'd0, 2'd2);
        chk("col_reload_count", dout, 32'd7);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
